crossbar_scheduler: RTL
=======================

Name: crossbar_scheduler

Overview:
Per-output arbiter and burst scheduler for the N×M crossbar_switch datapath. Each output port runs an independent round-robin arbiter over the inputs requesting it. The output is locked to the winner for a burst of len+1 beats. The block drives per-input grants and per-output select/busy signals that configure the crossbar muxes.

Parameters:
N, 4, number of input ports
M, 4, number of output ports
LW, 4, burst-length field width (len = beats-1)
IW (localparam), clog2(N), input index width
DW (localparam), clog2(M), destination width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N  req[i]: input i requests transfer; held with dest/len until done or abort
dest  in  N*DW  flattened; dest[i*DW +: DW] is the target output of input i
len  in  N*LW  flattened; burst beats-1 for input i, sampled at grant
beat  in  N  beat[i]: input i presents a valid data beat this cycle
grant  out  N  grant[i]: input i owns its destination output (registered)
done  out  N  one-cycle pulse: last beat of input i accepted
out_sel  out  M*IW  flattened; owning input index per output (crossbar mux select)
out_busy  out  M  output j is locked to an owner

Behaviour:
- Reset (rst_n=0, asynchronous, no clock edge needed): grant=0, done=0, out_sel=0, out_busy=0, all rr pointers=0, all counters=0, all outputs in IDLE.
- Per-output FSM, states IDLE and BUSY.
- IDLE, candidates for output j: req[i] && dest[i]==j && !grant[i]. Dest values >= M are never granted.
- Winner: first candidate at or after rr_ptr[j], searching cyclically.
- On the edge after arbitration: state=BUSY, out_sel[j]=winner, out_busy[j]=1, grant[winner]=1, cnt[j]=len[winner].
- Latency: req asserted in cycle t gives grant visible in cycle t+1.
- BUSY: dest and len changes of the owner are ignored (locked).
- Each cycle with beat[owner]=1 and cnt>0: cnt decrements. beat=0 stalls with no change.
- Last beat (beat[owner]=1 && cnt==0): done[owner] pulses in that same cycle (combinational from beat & cnt==0). Next edge: grant clears, out_busy clears, rr_ptr[j]=owner+1 mod N, state=IDLE.
- One mandatory idle bubble after each release; the next arbitration happens in IDLE.
- Abort: req[owner]=0 while BUSY. Next edge: release exactly as after the last beat, with no done pulse.
- An input is granted by at most one output, because it has a single dest. At most one grant is set per output.
- beat[i] while grant[i]=0 is ignored.
- out_sel holds its last value while IDLE. Consumers qualify it with out_busy.
- Simultaneous last beat and req drop by the owner count as completion: done pulses.

Decomposition:
- crossbar_pkg: N/M defaults, IW/DW/LW derivation, state enum {IDLE, BUSY}.
- Sub-module rr_arbiter (req vector N, ptr IW → one-hot gnt N, gnt_idx IW, gnt_vld), combinational, instantiated once per output.
- The scheduler holds the FSMs, counters, pointers and grant/done logic.

Test Plan:
- Reset: rst_n=0 mid-simulation with req=4'b1111 → grant/out_busy/done=0 immediately, without waiting for clk. Release with req=0 → outputs stay 0.
- Parallel: req=1111, dest={3,2,1,0}, len=0, beat=1111 → grant=1111 and out_sel[j]=j one cycle later; done=1111 that cycle; grant=0 the next.
- Rotation: all four inputs dest=1, len=0, beat=1111, req held (re-raised after done) → grant order 0,1,2,3,0, one grant every other cycle. out_sel[1] follows 0,1,2,3,0.
- Burst with stalls: input 2 dest=3, len=3, beat[2] toggling 1,0,1,0… → grant held 7 cycles; done[2] on 4th beat; out_busy[3] clears the next edge.
- Contention plus abort: input 0 and 3 dest=2, len=5. Input 0 granted; drop req[0] after 2 beats → grant[0] clears next edge with no done[0]. After one bubble grant[3]=1 and out_sel[2]=3.
- Lock: while input 1 is BUSY on output 0, change dest[1] to 2 and len[1] → grant persists on output 0; out_busy[2] stays 0; the original beat count completes.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared types and sizing helpers for the crossbar scheduler slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package crossbar_pkg;

   localparam int N_DEF  = 4;
   localparam int M_DEF  = 4;
   localparam int LW_DEF = 4;

   // Index width that stays at least one bit wide for single-port builds.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic {IDLE, BUSY} state_t;

endpackage

// File: rtl/crossbar_scheduler_if.sv
// Request/grant bundle between crossbar input ports and the scheduler.
// Latency: wires only.
// Backpressure: grant gates beats; a request is held until done or dropped.
interface crossbar_scheduler_if #(
   parameter int N  = crossbar_pkg::N_DEF,
   parameter int M  = crossbar_pkg::M_DEF,
   parameter int LW = crossbar_pkg::LW_DEF
) ();
   import crossbar_pkg::*;

   localparam int IW = idx_w(N);
   localparam int DW = idx_w(M);

   logic [N-1:0]    req;
   logic [N*DW-1:0] dest;
   logic [N*LW-1:0] len;
   logic [N-1:0]    beat;
   logic [N-1:0]    grant;
   logic [N-1:0]    done;
   logic [M*IW-1:0] out_sel;
   logic [M-1:0]    out_busy;

   modport master (
      output req, dest, len, beat,
      input  grant, done, out_sel, out_busy
   );

   modport slave (
      input  req, dest, len, beat,
      output grant, done, out_sel, out_busy
   );

endinterface

// File: rtl/crossbar_scheduler_rr_arbiter.sv
// Round-robin pick of the first requester at or after ptr, searching cyclically.
// Latency: combinational.
// Backpressure: none; gnt_vld low when no requester is present.
module rr_arbiter
   import crossbar_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_vld
);

   logic [IW-1:0] idx;

   // Walk the requesters starting at ptr and keep the first hit.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!gnt_vld && req[idx]) begin
            gnt_vld  = 1'b1;
            gnt_idx  = idx;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/crossbar_scheduler.sv
// Per-output round-robin arbiter and burst lock driving crossbar mux selects.
// Latency: req to grant one cycle; release one cycle after last beat, then one idle bubble.
// Backpressure: beat low stalls the burst counter; dropping req aborts the burst.
module crossbar_scheduler
   import crossbar_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int M  = M_DEF,
   parameter int LW = LW_DEF
) (
   input logic                 clk,
   input logic                 rst_n,
   crossbar_scheduler_if.slave bus
);

   localparam int IW = idx_w(N);
   localparam int DW = idx_w(M);

   logic [M-1:0][N-1:0]  own_vec;
   logic [M-1:0][N-1:0]  done_vec;
   logic [M-1:0][IW-1:0] sel_vec;
   logic [M-1:0]         busy_vec;
   logic [N-1:0]         grant_c;
   logic [N-1:0]         done_c;

   // Grants are decoded purely from per-output flops, so they never depend on
   // this cycle's inputs; done is the only combinational output.
   always_comb begin
      grant_c = '0;
      done_c  = '0;
      for (int j = 0; j < M; j++) begin
         grant_c = grant_c | own_vec[j];
         done_c  = done_c  | done_vec[j];
      end
   end

   assign bus.grant    = grant_c;
   assign bus.done     = done_c;
   assign bus.out_sel  = sel_vec;
   assign bus.out_busy = busy_vec;

   for (genvar j = 0; j < M; j++) begin : g_out
      state_t        state_q;
      logic [IW-1:0] sel_q;
      logic [IW-1:0] ptr_q;
      logic [LW-1:0] cnt_q;
      logic [N-1:0]  cand;
      logic [N-1:0]  arb_gnt;
      logic [IW-1:0] arb_idx;
      logic          arb_vld;
      logic [LW-1:0] len_win;
      logic          busy;
      logic          own_beat;
      logic          own_req;
      logic          last_beat;

      // Inputs already owning some output are excluded, so an input can never
      // be re-granted in the same cycle another output releases it.
      always_comb begin
         cand = '0;
         for (int i = 0; i < N; i++) begin
            cand[i] = bus.req[i] && (bus.dest[i*DW +: DW] == DW'(j)) && !grant_c[i];
         end
      end

      rr_arbiter #(.N(N), .IW(IW)) u_arb (
         .req     (cand),
         .ptr     (ptr_q),
         .gnt     (arb_gnt),
         .gnt_idx (arb_idx),
         .gnt_vld (arb_vld)
      );

      // One-hot mux of the winner's burst length.
      always_comb begin
         len_win = '0;
         for (int i = 0; i < N; i++) begin
            if (arb_gnt[i]) len_win = len_win | bus.len[i*LW +: LW];
         end
      end

      assign busy      = (state_q == BUSY);
      assign own_beat  = bus.beat[sel_q];
      assign own_req   = bus.req[sel_q];
      assign last_beat = busy && own_beat && (cnt_q == '0);

      assign own_vec[j]  = busy ? (N'(1) << sel_q) : '0;
      assign done_vec[j] = last_beat ? own_vec[j] : '0;
      assign sel_vec[j]  = sel_q;
      assign busy_vec[j] = busy;

      // Output FSM: lock to the winner, count beats, release on last beat or abort.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (arb_vld) begin
                     state_q <= BUSY;
                     sel_q   <= arb_idx;
                     cnt_q   <= len_win;
                  end
               end
               BUSY: begin
                  if (last_beat || !own_req) begin
                     state_q <= IDLE;
                     ptr_q   <= IW'((int'(sel_q) + 1) % N);
                  end else if (own_beat) begin
                     cnt_q <= cnt_q - LW'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule
